// File: rtl/ev22_fetch_pkg.sv
// Shared definitions for the EV22 instruction-byte fetch sequencer.
package ev22_fetch_pkg;

  typedef enum logic [2:0] {
    StResetIdle,
    StFetchOp,
    StFetchLo,
    StFetchHi,
    StIssue
  } fetch_state_e;

  localparam int unsigned IMM_FLAG_BIT = 7;

  function automatic logic is_fetch_state(fetch_state_e s);
    return (s == StFetchOp) || (s == StFetchLo) || (s == StFetchHi);
  endfunction

endpackage

// File: rtl/imm_fetch_seq.sv
// Opcode/immediate byte fetch sequencer feeding the constant register and decode.
// Build option IMM_BIG_ENDIAN_EN: first immediate byte goes to the high half.
module imm_fetch_seq
  import ev22_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [ADDR_W-1:0] pm_addr,
  output logic              pm_rd,
  input  logic [7:0]        pm_data,
  input  logic              pm_valid,
  output logic [7:0]        k_in,
  output logic              byte_select,
  output logic              ena,
  output logic [7:0]        opcode,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [ADDR_W-1:0] pc
);

`ifdef IMM_BIG_ENDIAN_EN
  localparam logic FIRST_SEL = 1'b1;
`else
  localparam logic FIRST_SEL = 1'b0;
`endif

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
  logic              pm_rd_q, pm_rd_d;
  logic [7:0]        k_in_q, k_in_d;
  logic              byte_sel_q, byte_sel_d;
  logic              ena_q, ena_d;
  logic [7:0]        opcode_q, opcode_d;
  logic              op_valid_q, op_valid_d;
  logic              outstanding_q, outstanding_d;
  logic              discard_q, discard_d;

  logic redirect;
  logic rsp;
  logic accept;
  logic still_outstanding;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pm_addr_d   = pm_addr_q;
    pm_rd_d     = 1'b0;
    k_in_d      = k_in_q;
    byte_sel_d  = byte_sel_q;
    ena_d       = 1'b0;
    opcode_d    = opcode_q;
    discard_d   = discard_q;

    redirect = pc_load && (state_q != StResetIdle);
    rsp      = pm_valid && outstanding_q;
    // A return for a redirected-away read, or one racing a redirect, carries stale data.
    accept   = rsp && !discard_q && !redirect;

    case (state_q)
      StResetIdle: state_d = StFetchOp;
      StFetchOp: begin
        if (accept) begin
          opcode_d = pm_data;
          state_d  = pm_data[IMM_FLAG_BIT] ? StFetchLo : StIssue;
        end
      end
      StFetchLo: begin
        if (accept) begin
          k_in_d     = pm_data;
          byte_sel_d = FIRST_SEL;
          ena_d      = 1'b1;
          state_d    = StFetchHi;
        end
      end
      StFetchHi: begin
        if (accept) begin
          k_in_d     = pm_data;
          byte_sel_d = ~FIRST_SEL;
          ena_d      = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (op_valid_q && op_ready) state_d = StFetchOp;
      end
      default: state_d = StResetIdle;
    endcase

    if (accept) pc_d = pc_q + ADDR_W'(1);

    if (redirect) begin
      pc_d    = pc_target;
      state_d = StFetchOp;
    end

    if (rsp) discard_d = 1'b0;
    if (redirect && outstanding_q && !pm_valid) discard_d = 1'b1;

    // Issue a read whenever a fetch state has nothing in flight; this also
    // delays the post-redirect read until the stale return has been dropped.
    still_outstanding = outstanding_q && !pm_valid;
    pm_rd_d           = is_fetch_state(state_d) && !still_outstanding;
    if (pm_rd_d) pm_addr_d = pc_d;
    outstanding_d = still_outstanding || pm_rd_d;

    op_valid_d = (state_d == StIssue);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= StResetIdle;
      pc_q          <= '0;
      pm_addr_q     <= '0;
      pm_rd_q       <= 1'b0;
      k_in_q        <= '0;
      byte_sel_q    <= 1'b0;
      ena_q         <= 1'b0;
      opcode_q      <= '0;
      op_valid_q    <= 1'b0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pm_addr_q     <= pm_addr_d;
      pm_rd_q       <= pm_rd_d;
      k_in_q        <= k_in_d;
      byte_sel_q    <= byte_sel_d;
      ena_q         <= ena_d;
      opcode_q      <= opcode_d;
      op_valid_q    <= op_valid_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign pm_addr     = pm_addr_q;
  assign pm_rd       = pm_rd_q;
  assign k_in        = k_in_q;
  assign byte_select = byte_sel_q;
  assign ena         = ena_q;
  assign opcode      = opcode_q;
  assign op_valid    = op_valid_q;
  assign pc          = pc_q;

endmodule
